// File: rtl/uart_tx_controller.sv
// Sequences ALU result bytes into the UART transmitter: one active byte plus one
// pending slot, a completion timeout, and sticky overflow/timeout flags.
module uart_tx_controller #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_TIMER       = 18,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned NB_STATES      = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  input  logic                 i_clear_status,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_data_valid,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_timeout,
  output logic [NB_STATES-1:0] o_dbg_state
);

  typedef enum logic [NB_STATES-1:0] {
    IDLE      = 3'b001,
    SEND      = 3'b010,
    WAIT_DONE = 3'b100
  } state_t;

  localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);

  state_t               state, state_next;
  logic [NB_DATA-1:0]   data_reg, data_next;
  logic [NB_DATA-1:0]   pending_reg, pending_next;
  logic                 pending_valid, pending_valid_next;
  logic [NB_TIMER-1:0]  timer, timer_next;
  logic                 overflow_reg, timeout_reg;
  logic                 overflow_set, timeout_set;
  logic                 expired;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      data_reg      <= '0;
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      timer         <= '0;
      overflow_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state         <= state_next;
      data_reg      <= data_next;
      pending_reg   <= pending_next;
      pending_valid <= pending_valid_next;
      timer         <= timer_next;
      // A flag being set wins over a clear arriving in the same cycle.
      if (overflow_set)        overflow_reg <= 1'b1;
      else if (i_clear_status) overflow_reg <= 1'b0;
      if (timeout_set)         timeout_reg  <= 1'b1;
      else if (i_clear_status) timeout_reg  <= 1'b0;
    end
  end

  always_comb begin
    state_next         = state;
    data_next          = data_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid;
    timer_next         = timer;
    overflow_set       = 1'b0;
    timeout_set        = 1'b0;
    expired            = 1'b0;

    case (state)
      IDLE: begin
        if (i_tx_start) begin
          data_next  = i_alu_result;
          state_next = SEND;
        end
      end

      SEND: begin
        timer_next = '0;
        state_next = WAIT_DONE;
        if (i_tx_start) begin
          if (!pending_valid) begin
            pending_next       = i_alu_result;
            pending_valid_next = 1'b1;
          end else begin
            overflow_set = 1'b1;
          end
        end
      end

      WAIT_DONE: begin
        timer_next = timer + NB_TIMER'(1);
        expired    = !i_tx_done && (timer == TIMER_LAST);
        if (i_tx_done || expired) begin
          timeout_set = expired;
          // With the slot full, the pending byte goes out and a simultaneous
          // new request refills the slot instead of overflowing.
          if (pending_valid) begin
            data_next  = pending_reg;
            state_next = SEND;
            if (i_tx_start) pending_next = i_alu_result;
            else            pending_valid_next = 1'b0;
          end else if (i_tx_start) begin
            data_next  = i_alu_result;
            state_next = SEND;
          end else begin
            state_next = IDLE;
          end
        end else if (i_tx_start) begin
          if (!pending_valid) begin
            pending_next       = i_alu_result;
            pending_valid_next = 1'b1;
          end else begin
            overflow_set = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign o_tx_data       = data_reg;
  assign o_tx_data_valid = (state == SEND);
  assign o_busy          = (state != IDLE) || pending_valid;
  assign o_overflow      = overflow_reg;
  assign o_timeout       = timeout_reg;
  assign o_dbg_state     = state;

endmodule
